// File: rtl/vec_mul_stream_engine.sv
// vec_mul_stream_engine: streaming element-wise pre-scaled vector multiplier.
// Each operand beat carries LANES signed elements. Stage 1 divides a and b by
// their constant pre-scale divisors, and stage 2 forms the full-width products.
// Mode 0 streams the products out. Mode 1 folds them into a dot-product accumulator.
//
// Handshakes: an input beat transfers on a clock edge where i_in_valid and
// o_in_ready are both high. An output beat transfers where o_out_valid and
// i_out_ready are both high. A source that has raised valid keeps its data
// stable until the transfer. The output side holds o_out_valid, o_out_data
// and o_out_last until they are accepted.
module vec_mul_stream_engine #(
    parameter int DATA_W  = 32,
    parameter int LANES   = 4,
    parameter int VEC_LEN = 100,
    parameter int DIV_A   = 50000000,
    parameter int DIV_B   = 43,
    parameter int ACC_W   = 48
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_cfg_mode,
    input  logic                      i_cfg_sat,
    output logic                      o_busy,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [LANES*DATA_W-1:0]   i_in_a,
    input  logic [LANES*DATA_W-1:0]   i_in_b,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [LANES*DATA_W-1:0]   o_out_data,
    output logic                      o_out_last,
    output logic                      o_dot_valid,
    output logic [DATA_W-1:0]         o_dot_result,
    output logic                      o_ovf,
    output logic [1:0]                o_dbg_state
);

    localparam int BEATS = (VEC_LEN + LANES - 1) / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int P_W   = 2 * DATA_W;
    localparam int EXT_W = (ACC_W > P_W) ? ACC_W : P_W;
    localparam logic signed [DATA_W-1:0] DIV_A_S = DATA_W'(DIV_A);
    localparam logic signed [DATA_W-1:0] DIV_B_S = DATA_W'(DIV_B);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_mode;
    logic                      r_sat;
    logic [CNT_W-1:0]          r_beat_cnt;
    logic                      r_s1_valid;
    logic                      r_s1_last;
    logic signed [DATA_W-1:0]  r_qa [LANES];
    logic signed [DATA_W-1:0]  r_qb [LANES];
    logic                      r_out_valid;
    logic [LANES*DATA_W-1:0]   r_out_data;
    logic                      r_out_last;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_dot_valid;
    logic [DATA_W-1:0]         r_dot_result;
    logic                      r_ovf;

    logic                      w_adv;
    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_last_beat;
    logic signed [DATA_W-1:0]  w_qa [LANES];
    logic signed [DATA_W-1:0]  w_qb [LANES];
    logic signed [P_W-1:0]     w_p [LANES];
    logic [DATA_W:0]           w_fit [LANES];
    logic [LANES*DATA_W-1:0]   w_out_pack;
    logic                      w_lane_lost;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic [DATA_W:0]           w_dot;

    // Narrow a wide signed value to DATA_W bits. Bit DATA_W of the result flags
    // that the kept value differs from the input. Saturation clamps toward the sign of v.
    function automatic logic [DATA_W:0] fit(input logic signed [EXT_W-1:0] v, input logic sat);
        logic [DATA_W-1:0]        lo;
        logic signed [EXT_W-1:0]  back;
        logic                     lost;
        lo   = v[DATA_W-1:0];
        back = EXT_W'($signed(lo));
        lost = (back != v);
        if (sat && lost) begin
            lo = v[EXT_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
        return {lost, lo};
    endfunction

    // Mode 1 never raises o_out_valid, so the pipeline always advances in that mode.
    assign w_adv       = !r_out_valid || i_out_ready;
    assign w_accept    = i_in_valid && w_in_ready;
    assign w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        o_busy       = (r_state != ST_IDLE);
        w_in_ready   = (r_state == ST_RUN) && w_adv;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_next = ST_RUN;
            ST_RUN:   if (w_accept && w_last_beat) w_state_next = ST_FLUSH;
            ST_FLUSH: begin
                if (!r_mode) begin
                    if (r_out_valid && i_out_ready && r_out_last) w_state_next = ST_IDLE;
                end else if (r_dot_valid) begin
                    w_state_next = ST_IDLE;
                end
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Stage 1 quotients. Lanes past the vector end are forced to zero, so their
    // products are zero and never flag overflow.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_qa[k] = '0;
            w_qb[k] = '0;
            if ((int'(r_beat_cnt) * LANES + k) < VEC_LEN) begin
                w_qa[k] = $signed(i_in_a[k*DATA_W +: DATA_W]) / DIV_A_S;
                w_qb[k] = $signed(i_in_b[k*DATA_W +: DATA_W]) / DIV_B_S;
            end
        end
    end

    // Stage 2 products, the narrowed lane results and the accumulator update
    always_comb begin
        w_sum       = '0;
        w_out_pack  = '0;
        w_lane_lost = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            w_p[k]   = $signed({{DATA_W{r_qa[k][DATA_W-1]}}, r_qa[k]}) *
                       $signed({{DATA_W{r_qb[k][DATA_W-1]}}, r_qb[k]});
            w_fit[k] = fit(EXT_W'(w_p[k]), r_sat);
            w_out_pack[k*DATA_W +: DATA_W] = w_fit[k][DATA_W-1:0];
            w_lane_lost = w_lane_lost | w_fit[k][DATA_W];
            w_sum = w_sum + ACC_W'(w_p[k]);
        end
        w_acc_next = r_acc + w_sum;
        w_dot      = fit(EXT_W'(w_acc_next), r_sat);
    end

    // Config latch, beat counter, the two pipeline stages, the accumulator and sticky overflow
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode       <= 1'b0;
            r_sat        <= 1'b0;
            r_beat_cnt   <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_qa         <= '{default: '0};
            r_qb         <= '{default: '0};
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_acc        <= '0;
            r_dot_valid  <= 1'b0;
            r_dot_result <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_dot_valid <= 1'b0;
            if (r_state == ST_IDLE && i_start) begin
                r_mode     <= i_cfg_mode;
                r_sat      <= i_cfg_sat;
                r_beat_cnt <= '0;
                r_acc      <= '0;
                r_ovf      <= 1'b0;
            end
            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
            if (w_adv) begin
                r_s1_valid <= w_accept;
                r_s1_last  <= w_accept && w_last_beat;
                if (w_accept) begin
                    r_qa <= w_qa;
                    r_qb <= w_qb;
                end
                if (!r_mode) begin
                    r_out_valid <= r_s1_valid;
                    r_out_last  <= r_s1_valid && r_s1_last;
                    if (r_s1_valid) begin
                        r_out_data <= w_out_pack;
                        if (w_lane_lost) r_ovf <= 1'b1;
                    end
                end else if (r_s1_valid) begin
                    r_acc <= w_acc_next;
                    if (r_s1_last) begin
                        r_dot_valid  <= 1'b1;
                        r_dot_result <= w_dot[DATA_W-1:0];
                        if (w_dot[DATA_W]) r_ovf <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_out_last   = r_out_last;
    assign o_dot_valid  = r_dot_valid;
    assign o_dot_result = r_dot_result;
    assign o_ovf        = r_ovf;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_vec_mul_stream_engine.sv
// Bench for vec_mul_stream_engine. It builds a LANES=4 instance and a LANES=3
// instance. Each accepted beat pushes its modelled result to an expected queue.
// That entry is popped and compared when the output beat handshakes.
module tb_vec_mul_stream_engine;

    localparam int DW   = 32;
    localparam int B4   = 25;
    localparam int B3   = 34;
    localparam int VLEN = 100;
    localparam int DIVA = 50000000;
    localparam int DIVB = 43;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT, LANES=4 ----------------
    logic         start, cfg_mode, cfg_sat, busy, in_valid, in_ready;
    logic [127:0] in_a, in_b, out_data;
    logic         out_valid, out_ready, out_last, dot_valid, ovf;
    logic [31:0]  dot_result;
    logic [1:0]   dbg_state;

    vec_mul_stream_engine #(.DATA_W(32), .LANES(4), .VEC_LEN(100)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_cfg_mode(cfg_mode),
        .i_cfg_sat(cfg_sat), .o_busy(busy), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .i_in_a(in_a), .i_in_b(in_b),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_out_last(out_last), .o_dot_valid(dot_valid), .o_dot_result(dot_result),
        .o_ovf(ovf), .o_dbg_state(dbg_state)
    );

    // ---------------- DUT, LANES=3 ----------------
    logic         s3_start, s3_cfg_mode, s3_cfg_sat, s3_busy, s3_in_valid, s3_in_ready;
    logic [95:0]  s3_in_a, s3_in_b, s3_out_data;
    logic         s3_out_valid, s3_out_ready, s3_out_last, s3_dot_valid, s3_ovf;
    logic [31:0]  s3_dot_result;
    logic [1:0]   s3_dbg_state;

    vec_mul_stream_engine #(.DATA_W(32), .LANES(3), .VEC_LEN(100)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(s3_start), .i_cfg_mode(s3_cfg_mode),
        .i_cfg_sat(s3_cfg_sat), .o_busy(s3_busy), .i_in_valid(s3_in_valid),
        .o_in_ready(s3_in_ready), .i_in_a(s3_in_a), .i_in_b(s3_in_b),
        .o_out_valid(s3_out_valid), .i_out_ready(s3_out_ready), .o_out_data(s3_out_data),
        .o_out_last(s3_out_last), .o_dot_valid(s3_dot_valid), .o_dot_result(s3_dot_result),
        .o_ovf(s3_ovf), .o_dbg_state(s3_dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [128:0] exp_q[$];
    int           cyc_q[$];
    logic [96:0]  exp3_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint prod_m(input logic [31:0] a, input logic [31:0] b);
        int qa;
        int qb;
        qa = $signed(a) / DIVA;
        qb = $signed(b) / DIVB;
        return longint'(qa) * longint'(qb);
    endfunction

    function automatic logic [32:0] conv_m(input longint v, input bit sat);
        longint      maxv = 64'sd2147483647;
        longint      minv = -64'sd2147483648;
        logic [63:0] u;
        u = v;
        if (v > maxv) return {1'b1, (sat ? 32'h7FFFFFFF : u[31:0])};
        if (v < minv) return {1'b1, (sat ? 32'h80000000 : u[31:0])};
        return {1'b0, u[31:0]};
    endfunction

    function automatic void gen_ab(input int pat, input int idx, output logic [31:0] a,
                                   output logic [31:0] b);
        logic [31:0] ha;
        logic [31:0] hb;
        ha = (idx * 32'h9E3779B9) ^ 32'h5BD1E995;
        hb = (idx * 32'h85EBCA6B) + 32'd7;
        case (pat)
            0: begin a = 32'd150000000; b = 32'd430; end
            1: begin a = ha; b = hb; end
            2: begin a = 32'h7FFFFFFF; b = 32'h7FFFFFFF; end
            default: begin
                case (idx % 4)
                    0: begin a = 32'(-99999999); b = 32'd86; end
                    1: begin a = 32'd49999999;   b = 32'd1000; end
                    2: begin a = 32'h80000000;   b = 32'h80000000; end
                    default: begin a = ha; b = hb; end
                endcase
            end
        endcase
    endfunction

    function automatic void fill4(input int pat, input int beat, output logic [127:0] a,
                                  output logic [127:0] b);
        logic [31:0] ea;
        logic [31:0] eb;
        a = '0;
        b = '0;
        for (int k = 0; k < 4; k++) begin
            gen_ab(pat, beat * 4 + k, ea, eb);
            a[k*32 +: 32] = ea;
            b[k*32 +: 32] = eb;
        end
    endfunction

    // ---------------- driver: one vector op on the LANES=4 instance ----------------
    // Entered and left at a falling edge. rst_at > 0 pulses reset after that many accepted beats.
    task automatic run_op(input bit mode, input bit sat, input int pat, input bit bp,
                          input int rst_at, output longint sig);
        logic [127:0] ca;
        logic [127:0] cb;
        logic [128:0] e;
        logic [32:0]  f;
        logic [31:0]  ea;
        logic [31:0]  eb;
        longint       p;
        longint       acc_m = 0;
        bit           exp_ovf = 1'b0;
        bit           dot_seen = 1'b0;
        bit           done = 1'b0;
        int           sent = 0;
        int           pops = 0;
        int           cycles;
        int           last_acc_cyc = 0;
        int           c;
        sig = 0;
        exp_q.delete();
        cyc_q.delete();
        cfg_mode = mode;
        cfg_sat  = sat;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fill4(pat, 0, ca, cb);
        for (cycles = 0; cycles < 3000 && !done; cycles++) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (sent < B4);
            in_a      = ca;
            in_b      = cb;
            #1;
            if (mode) chk("m1_out_valid", out_valid, 0);
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                chk("out_beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    chk("out_beat", {out_last, out_data}, e);
                    if (!bp) chk("latency", cycles - c, 2);
                    if (pat == 3) begin
                        chk("trunc_lane0", out_data[31:0], 32'hFFFFFFFE);
                        chk("trunc_lane1", out_data[63:32], 32'd0);
                        chk("trunc_lane2", out_data[95:64], 32'd2097542160);
                    end
                    sig = sig * 31 + longint'(out_data[63:0] ^ out_data[127:64]);
                    pops++;
                end
            end
            if (dot_valid) begin
                f = conv_m(acc_m, sat);
                chk("dot_result", dot_result, f[31:0]);
                if (!bp) chk("dot_latency", cycles - last_acc_cyc, 2);
                dot_seen = 1'b1;
            end
            if (in_valid && in_ready) begin
                e = '0;
                for (int k = 0; k < 4; k++) begin
                    if (sent * 4 + k < VLEN) begin
                        gen_ab(pat, sent * 4 + k, ea, eb);
                        p = prod_m(ea, eb);
                        f = conv_m(p, sat);
                        e[k*32 +: 32] = f[31:0];
                        if (!mode) exp_ovf = exp_ovf | f[32];
                        acc_m = acc_m + p;
                    end
                end
                e[128] = (sent == B4 - 1);
                if (!mode) begin
                    exp_q.push_back(e);
                    cyc_q.push_back(cycles);
                end
                last_acc_cyc = cycles;
                sent++;
                fill4(pat, sent, ca, cb);
                if (sent == rst_at) begin
                    rst      = 1'b1;
                    in_valid = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    #1;
                    chk("rst_busy", busy, 0);
                    chk("rst_out_valid", out_valid, 0);
                    chk("rst_in_ready", in_ready, 0);
                    exp_q.delete();
                    cyc_q.delete();
                    @(negedge clk);
                    return;
                end
            end
            done = (sent == B4) && (mode ? dot_seen : (exp_q.size() == 0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) chk("timeout", done, 1);
        if (mode) begin
            f = conv_m(acc_m, sat);
            exp_ovf = f[32];
        end
        #1;
        chk("busy_end", busy, 0);
        chk("ovf_end", ovf, exp_ovf);
        if (mode) chk("dot_single_pulse", dot_valid, 0);
        else chk("beat_count", pops, B4);
        @(negedge clk);
    endtask

    // ---------------- driver: tail-masking run on the LANES=3 instance ----------------
    task automatic run3();
        logic [96:0] e;
        logic [32:0] f;
        bit          done = 1'b0;
        int          sent = 0;
        int          pops = 0;
        int          cycles;
        exp3_q.delete();
        s3_cfg_mode = 1'b0;
        s3_cfg_sat  = 1'b0;
        s3_start    = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        for (cycles = 0; cycles < 3000 && !done; cycles++) begin
            s3_out_ready = 1'b1;
            s3_in_valid  = (sent < B3);
            s3_in_a      = {3{32'd150000000}};
            s3_in_b      = {3{32'd430}};
            #1;
            if (s3_out_valid) begin
                chk("l3_out_expected", exp3_q.size() > 0, 1);
                if (exp3_q.size() > 0) begin
                    e = exp3_q.pop_front();
                    chk("l3_beat", {s3_out_last, s3_out_data}, e);
                    pops++;
                    if (pops == B3) begin
                        chk("l3_tail_lane0", s3_out_data[31:0], 32'd30);
                        chk("l3_tail_lane1", s3_out_data[63:32], 32'd0);
                        chk("l3_tail_lane2", s3_out_data[95:64], 32'd0);
                        chk("l3_tail_last", s3_out_last, 1);
                    end
                end
            end
            if (s3_in_valid && s3_in_ready) begin
                e = '0;
                for (int k = 0; k < 3; k++) begin
                    if (sent * 3 + k < VLEN) begin
                        f = conv_m(prod_m(32'd150000000, 32'd430), 1'b0);
                        e[k*32 +: 32] = f[31:0];
                    end
                end
                e[96] = (sent == B3 - 1);
                exp3_q.push_back(e);
                sent++;
            end
            done = (sent == B3) && (exp3_q.size() == 0);
            @(negedge clk);
        end
        s3_in_valid = 1'b0;
        if (!done) chk("l3_timeout", done, 1);
        #1;
        chk("l3_busy_end", s3_busy, 0);
        chk("l3_beat_count", pops, B3);
        chk("l3_ovf", s3_ovf, 0);
        @(negedge clk);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        longint sig_ref;
        longint sig_bp;
        longint sig_x;
        rst = 1'b1;
        start = 1'b0; cfg_mode = 1'b0; cfg_sat = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        s3_start = 1'b0; s3_cfg_mode = 1'b0; s3_cfg_sat = 1'b0; s3_in_valid = 1'b0;
        s3_in_a = '0; s3_in_b = '0; s3_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_dot_valid", dot_valid, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_dot_result", dot_result, 0);
        chk("reset_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b0, 1'b0, 0, 1'b0, -1, sig_x);
        run_op(1'b0, 1'b0, 3, 1'b0, -1, sig_x);
        run_op(1'b0, 1'b1, 1, 1'b0, -1, sig_ref);
        run_op(1'b0, 1'b1, 1, 1'b1, -1, sig_bp);
        chk("bp_stream_match", sig_bp, sig_ref);
        run_op(1'b1, 1'b1, 2, 1'b0, -1, sig_x);
        run_op(1'b1, 1'b0, 2, 1'b0, -1, sig_x);
        run_op(1'b1, 1'b0, 1, 1'b0, -1, sig_x);
        run_op(1'b0, 1'b0, 0, 1'b0, 10, sig_x);
        run_op(1'b0, 1'b0, 0, 1'b0, -1, sig_x);
        run3();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
